// File: rtl/sda_gmem_axi_pkg.sv
// Shared AXI encodings and FSM state types for the gmem RAM responder.
package sda_gmem_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/sda_gmem_ram_dp.sv
// Simple dual-port word RAM: byte-enable write port, registered read port
// with read enable. A read and a write to the same word on one edge return
// the old contents (read-first). Contents are never cleared.
module sda_gmem_ram_dp #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_BITS  = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_BITS-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [ADDR_BITS-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [0:(1 << ADDR_BITS)-1];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Byte-lane write: only lanes with their strobe set are updated.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (we && wstrb[b]) begin
                mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Registered read; output holds its value while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sda_gmem_axi_ram_responder.sv
// AXI4 slave backed by an on-chip word RAM, standing in for shell memory on
// the kernel gmem port. Independent read and write FSMs, one outstanding
// transaction per direction, IDs echoed in order.
module sda_gmem_axi_ram_responder
    import sda_gmem_axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 1,
    parameter int USER_WIDTH     = 1,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    // write address
    input  logic [ADDR_WIDTH-1:0]   s_axi_gmem_awaddr,
    input  logic [7:0]              s_axi_gmem_awlen,
    input  logic [2:0]              s_axi_gmem_awsize,
    input  logic [1:0]              s_axi_gmem_awburst,
    input  logic [ID_WIDTH-1:0]     s_axi_gmem_awid,
    input  logic                    s_axi_gmem_awlock,
    input  logic [3:0]              s_axi_gmem_awcache,
    input  logic [2:0]              s_axi_gmem_awprot,
    input  logic [3:0]              s_axi_gmem_awqos,
    input  logic [3:0]              s_axi_gmem_awregion,
    input  logic [USER_WIDTH-1:0]   s_axi_gmem_awuser,
    input  logic                    s_axi_gmem_awvalid,
    output logic                    s_axi_gmem_awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   s_axi_gmem_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_gmem_wstrb,
    input  logic                    s_axi_gmem_wlast,
    input  logic                    s_axi_gmem_wvalid,
    output logic                    s_axi_gmem_wready,
    // write response
    output logic [1:0]              s_axi_gmem_bresp,
    output logic [ID_WIDTH-1:0]     s_axi_gmem_bid,
    output logic [USER_WIDTH-1:0]   s_axi_gmem_buser,
    output logic                    s_axi_gmem_bvalid,
    input  logic                    s_axi_gmem_bready,
    // read address
    input  logic [ADDR_WIDTH-1:0]   s_axi_gmem_araddr,
    input  logic [7:0]              s_axi_gmem_arlen,
    input  logic [2:0]              s_axi_gmem_arsize,
    input  logic [1:0]              s_axi_gmem_arburst,
    input  logic [ID_WIDTH-1:0]     s_axi_gmem_arid,
    input  logic                    s_axi_gmem_arlock,
    input  logic [3:0]              s_axi_gmem_arcache,
    input  logic [2:0]              s_axi_gmem_arprot,
    input  logic [3:0]              s_axi_gmem_arqos,
    input  logic [3:0]              s_axi_gmem_arregion,
    input  logic [USER_WIDTH-1:0]   s_axi_gmem_aruser,
    input  logic                    s_axi_gmem_arvalid,
    output logic                    s_axi_gmem_arready,
    // read data
    output logic [DATA_WIDTH-1:0]   s_axi_gmem_rdata,
    output logic [1:0]              s_axi_gmem_rresp,
    output logic                    s_axi_gmem_rlast,
    output logic [ID_WIDTH-1:0]     s_axi_gmem_rid,
    output logic [USER_WIDTH-1:0]   s_axi_gmem_ruser,
    output logic                    s_axi_gmem_rvalid,
    input  logic                    s_axi_gmem_rready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int HI    = OFFS + MEM_DEPTH_LOG2;
    localparam int IW    = MEM_DEPTH_LOG2;
    localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};

    // Out-of-range address, non-native beat size or WRAP burst all answer SLVERR.
    function automatic logic req_err(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [2:0]            size,
                                     input logic [1:0]            burst);
        req_err = ((a >> HI) != '0) || (size != OFFS[2:0]) || (burst == AXI_BURST_WRAP);
    endfunction

    // ---------------- write channel ----------------
    w_state_t              w_state_r, w_state_s;
    logic                  awready_r, awready_s;
    logic                  wready_r, wready_s;
    logic                  bvalid_r, bvalid_s;
    logic [1:0]            bresp_r, bresp_s;
    logic [ID_WIDTH-1:0]   bid_r, bid_s;
    logic [ID_WIDTH-1:0]   w_id_r, w_id_s;
    logic [7:0]            w_len_r, w_len_s;
    logic [7:0]            w_cnt_r, w_cnt_s;
    logic [IW-1:0]         w_idx_r, w_idx_s;
    logic                  w_err_r, w_err_s;
    logic                  w_fixed_r, w_fixed_s;
    logic                  w_last_beat_s;
    logic                  ram_we_s;

    // Write FSM next-state and next register values; RAM write strobe.
    always_comb begin
        w_state_s     = w_state_r;
        awready_s     = awready_r;
        wready_s      = wready_r;
        bvalid_s      = bvalid_r;
        bresp_s       = bresp_r;
        bid_s         = bid_r;
        w_id_s        = w_id_r;
        w_len_s       = w_len_r;
        w_cnt_s       = w_cnt_r;
        w_idx_s       = w_idx_r;
        w_err_s       = w_err_r;
        w_fixed_s     = w_fixed_r;
        ram_we_s      = 1'b0;
        w_last_beat_s = (w_cnt_r == w_len_r);
        case (w_state_r)
            W_IDLE: begin
                if (s_axi_gmem_awvalid && awready_r) begin
                    w_id_s    = s_axi_gmem_awid;
                    w_len_s   = s_axi_gmem_awlen;
                    w_cnt_s   = 8'd0;
                    w_idx_s   = s_axi_gmem_awaddr[OFFS +: IW];
                    w_err_s   = req_err(s_axi_gmem_awaddr, s_axi_gmem_awsize, s_axi_gmem_awburst);
                    w_fixed_s = (s_axi_gmem_awburst == AXI_BURST_FIXED);
                    awready_s = 1'b0;
                    wready_s  = 1'b1;
                    w_state_s = W_DATA;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_DATA: begin
                if (s_axi_gmem_wvalid && wready_r) begin
                    ram_we_s = !w_err_r;
                    // Burst closes on whichever comes first: the counted last beat or wlast.
                    if (w_last_beat_s || s_axi_gmem_wlast) begin
                        wready_s  = 1'b0;
                        bvalid_s  = 1'b1;
                        bid_s     = w_id_r;
                        bresp_s   = (w_err_r || (w_last_beat_s != s_axi_gmem_wlast))
                                    ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        w_state_s = W_RESP;
                    end else begin
                        w_cnt_s = w_cnt_r + 8'd1;
                        w_idx_s = w_fixed_r ? w_idx_r : (w_idx_r + IDX_ONE);
                    end
                end else begin
                    w_state_s = W_DATA;
                end
            end
            W_RESP: begin
                if (bvalid_r && s_axi_gmem_bready) begin
                    bvalid_s  = 1'b0;
                    awready_s = 1'b1;
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: begin
                awready_s = 1'b1;
                wready_s  = 1'b0;
                bvalid_s  = 1'b0;
                w_state_s = W_IDLE;
            end
        endcase
    end

    // Write FSM state and registered write-channel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= AXI_RESP_OKAY;
            bid_r     <= '0;
            w_id_r    <= '0;
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_idx_r   <= '0;
            w_err_r   <= 1'b0;
            w_fixed_r <= 1'b0;
        end else begin
            w_state_r <= w_state_s;
            awready_r <= awready_s;
            wready_r  <= wready_s;
            bvalid_r  <= bvalid_s;
            bresp_r   <= bresp_s;
            bid_r     <= bid_s;
            w_id_r    <= w_id_s;
            w_len_r   <= w_len_s;
            w_cnt_r   <= w_cnt_s;
            w_idx_r   <= w_idx_s;
            w_err_r   <= w_err_s;
            w_fixed_r <= w_fixed_s;
        end
    end

    // ---------------- read channel ----------------
    r_state_t              r_state_r, r_state_s;
    logic                  arready_r, arready_s;
    logic                  rvalid_r, rvalid_s;
    logic                  rlast_r, rlast_s;
    logic [1:0]            rresp_r, rresp_s;
    logic [ID_WIDTH-1:0]   rid_r, rid_s;
    logic [7:0]            r_len_r, r_len_s;
    logic [7:0]            r_cnt_r, r_cnt_s;
    logic [IW-1:0]         r_idx_r, r_idx_s;
    logic                  r_err_r, r_err_s;
    logic                  r_fixed_r, r_fixed_s;
    logic                  ram_re_s;
    logic [IW-1:0]         ram_raddr_s;
    logic [IW-1:0]         ar_idx_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    assign ar_idx_s = s_axi_gmem_araddr[OFFS +: IW];

    // Read FSM next-state; r_idx_r always points at the next word to fetch.
    always_comb begin
        r_state_s   = r_state_r;
        arready_s   = arready_r;
        rvalid_s    = rvalid_r;
        rlast_s     = rlast_r;
        rresp_s     = rresp_r;
        rid_s       = rid_r;
        r_len_s     = r_len_r;
        r_cnt_s     = r_cnt_r;
        r_idx_s     = r_idx_r;
        r_err_s     = r_err_r;
        r_fixed_s   = r_fixed_r;
        ram_re_s    = 1'b0;
        ram_raddr_s = r_idx_r;
        case (r_state_r)
            R_IDLE: begin
                if (s_axi_gmem_arvalid && arready_r) begin
                    ram_re_s    = 1'b1;
                    ram_raddr_s = ar_idx_s;
                    r_fixed_s   = (s_axi_gmem_arburst == AXI_BURST_FIXED);
                    r_idx_s     = (s_axi_gmem_arburst == AXI_BURST_FIXED) ? ar_idx_s
                                                                          : (ar_idx_s + IDX_ONE);
                    r_err_s     = req_err(s_axi_gmem_araddr, s_axi_gmem_arsize, s_axi_gmem_arburst);
                    rresp_s     = req_err(s_axi_gmem_araddr, s_axi_gmem_arsize, s_axi_gmem_arburst)
                                  ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    r_len_s     = s_axi_gmem_arlen;
                    r_cnt_s     = 8'd0;
                    rid_s       = s_axi_gmem_arid;
                    rlast_s     = (s_axi_gmem_arlen == 8'd0);
                    rvalid_s    = 1'b1;
                    arready_s   = 1'b0;
                    r_state_s   = R_DATA;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (rvalid_r && s_axi_gmem_rready) begin
                    if (rlast_r) begin
                        rvalid_s  = 1'b0;
                        rlast_s   = 1'b0;
                        arready_s = 1'b1;
                        r_state_s = R_IDLE;
                    end else begin
                        // Fetch the next beat on the same edge as the handshake.
                        ram_re_s    = 1'b1;
                        ram_raddr_s = r_idx_r;
                        r_idx_s     = r_fixed_r ? r_idx_r : (r_idx_r + IDX_ONE);
                        r_cnt_s     = r_cnt_r + 8'd1;
                        rlast_s     = ((r_cnt_r + 8'd1) == r_len_r);
                    end
                end else begin
                    r_state_s = R_DATA;
                end
            end
            default: begin
                arready_s = 1'b1;
                rvalid_s  = 1'b0;
                rlast_s   = 1'b0;
                r_state_s = R_IDLE;
            end
        endcase
    end

    // Read FSM state and registered read-channel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= AXI_RESP_OKAY;
            rid_r     <= '0;
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            r_idx_r   <= '0;
            r_err_r   <= 1'b0;
            r_fixed_r <= 1'b0;
        end else begin
            r_state_r <= r_state_s;
            arready_r <= arready_s;
            rvalid_r  <= rvalid_s;
            rlast_r   <= rlast_s;
            rresp_r   <= rresp_s;
            rid_r     <= rid_s;
            r_len_r   <= r_len_s;
            r_cnt_r   <= r_cnt_s;
            r_idx_r   <= r_idx_s;
            r_err_r   <= r_err_s;
            r_fixed_r <= r_fixed_s;
        end
    end

    sda_gmem_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (IW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (w_idx_r),
        .wdata (s_axi_gmem_wdata),
        .wstrb (s_axi_gmem_wstrb),
        .re    (ram_re_s),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    // Sideband fields carry no meaning for this responder.
    logic unused_s;
    assign unused_s = ^{s_axi_gmem_awlock, s_axi_gmem_awcache, s_axi_gmem_awprot,
                        s_axi_gmem_awqos, s_axi_gmem_awregion, s_axi_gmem_awuser,
                        s_axi_gmem_arlock, s_axi_gmem_arcache, s_axi_gmem_arprot,
                        s_axi_gmem_arqos, s_axi_gmem_arregion, s_axi_gmem_aruser};

    assign s_axi_gmem_awready = awready_r;
    assign s_axi_gmem_wready  = wready_r;
    assign s_axi_gmem_bvalid  = bvalid_r;
    assign s_axi_gmem_bresp   = bresp_r;
    assign s_axi_gmem_bid     = bid_r;
    assign s_axi_gmem_buser   = '0;
    assign s_axi_gmem_arready = arready_r;
    assign s_axi_gmem_rvalid  = rvalid_r;
    assign s_axi_gmem_rlast   = rlast_r;
    assign s_axi_gmem_rresp   = rresp_r;
    assign s_axi_gmem_rid     = rid_r;
    assign s_axi_gmem_ruser   = '0;
    // RAM output register is not reset, so data is only exposed on a valid, error-free beat.
    assign s_axi_gmem_rdata   = (rvalid_r && !r_err_r) ? ram_rdata_s : '0;

endmodule

// File: tb/tb_sda_gmem_axi_ram_responder.sv
// Directed bench for the gmem AXI RAM responder with a word-level memory
// model and scoreboard queues for expected R beats and B responses.
module tb_sda_gmem_axi_ram_responder;
    import sda_gmem_axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [63:0] awaddr;  logic [7:0] awlen;  logic [2:0] awsize;  logic [1:0] awburst;
    logic        awid;    logic awvalid;      logic awready;
    logic [63:0] wdata;   logic [7:0] wstrb;  logic wlast;  logic wvalid;  logic wready;
    logic [1:0]  bresp;   logic bid;  logic buser;  logic bvalid;  logic bready;
    logic [63:0] araddr;  logic [7:0] arlen;  logic [2:0] arsize;  logic [1:0] arburst;
    logic        arid;    logic arvalid;      logic arready;
    logic [63:0] rdata;   logic [1:0] rresp;  logic rlast;  logic rid;  logic ruser;
    logic        rvalid;  logic rready;

    sda_gmem_axi_ram_responder dut (
        .clk(clk), .reset(reset),
        .s_axi_gmem_awaddr(awaddr), .s_axi_gmem_awlen(awlen), .s_axi_gmem_awsize(awsize),
        .s_axi_gmem_awburst(awburst), .s_axi_gmem_awid(awid),
        .s_axi_gmem_awlock(1'b0), .s_axi_gmem_awcache(4'd0), .s_axi_gmem_awprot(3'd0),
        .s_axi_gmem_awqos(4'd0), .s_axi_gmem_awregion(4'd0), .s_axi_gmem_awuser(1'b0),
        .s_axi_gmem_awvalid(awvalid), .s_axi_gmem_awready(awready),
        .s_axi_gmem_wdata(wdata), .s_axi_gmem_wstrb(wstrb), .s_axi_gmem_wlast(wlast),
        .s_axi_gmem_wvalid(wvalid), .s_axi_gmem_wready(wready),
        .s_axi_gmem_bresp(bresp), .s_axi_gmem_bid(bid), .s_axi_gmem_buser(buser),
        .s_axi_gmem_bvalid(bvalid), .s_axi_gmem_bready(bready),
        .s_axi_gmem_araddr(araddr), .s_axi_gmem_arlen(arlen), .s_axi_gmem_arsize(arsize),
        .s_axi_gmem_arburst(arburst), .s_axi_gmem_arid(arid),
        .s_axi_gmem_arlock(1'b0), .s_axi_gmem_arcache(4'd0), .s_axi_gmem_arprot(3'd0),
        .s_axi_gmem_arqos(4'd0), .s_axi_gmem_arregion(4'd0), .s_axi_gmem_aruser(1'b0),
        .s_axi_gmem_arvalid(arvalid), .s_axi_gmem_arready(arready),
        .s_axi_gmem_rdata(rdata), .s_axi_gmem_rresp(rresp), .s_axi_gmem_rlast(rlast),
        .s_axi_gmem_rid(rid), .s_axi_gmem_ruser(ruser),
        .s_axi_gmem_rvalid(rvalid), .s_axi_gmem_rready(rready)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] model [0:1023];

    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic id; } rbeat_t;
    typedef struct { logic [1:0] resp; logic id; } bexp_t;
    rbeat_t r_q[$];
    bexp_t  b_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] strb);
        logic [63:0] m;
        m = old;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) m[b*8 +: 8] = d[b*8 +: 8];
        end
        return m;
    endfunction

    task automatic do_aw(input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic id);
        bit hs;
        hs = 1'b0;
        awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awid = id; awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (awready === 1'b1) begin hs = 1'b1; tick(); break; end
            tick();
        end
        awvalid = 1'b0;
        check("aw_handshake", 64'(hs), 64'd1);
    endtask

    task automatic do_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
        bit hs;
        hs = 1'b0;
        wdata = d; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (wready === 1'b1) begin hs = 1'b1; tick(); break; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("w_handshake", 64'(hs), 64'd1);
    endtask

    task automatic get_b();
        bexp_t e;
        bit hs;
        hs = 1'b0;
        e = b_q.pop_front();
        check("wready_in_resp", 64'(wready), 64'd0);
        bready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bvalid === 1'b1) begin
                check("bresp", 64'(bresp), 64'(e.resp));
                check("bid", 64'(bid), 64'(e.id));
                hs = 1'b1; tick(); break;
            end
            tick();
        end
        bready = 1'b0;
        check("b_handshake", 64'(hs), 64'd1);
        check("awready_after_b", 64'(awready), 64'd1);
    endtask

    // Full write transaction; last_at is the beat index carrying wlast.
    task automatic write_burst(input logic [63:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic id,
                               input logic [63:0] base, input logic [7:0] strb,
                               input int last_at, input logic [1:0] exp_resp);
        logic [9:0]  idx;
        logic [63:0] d;
        idx = addr[12:3];
        b_q.push_back('{resp: exp_resp, id: id});
        do_aw(addr, len, burst, id);
        check("aw_w_exclusive", {62'd0, awready, wready}, 64'd1);
        for (int b = 0; b <= last_at; b++) begin
            d = base * 64'(b + 1);
            do_w(d, strb, (b == last_at));
            if (exp_resp == AXI_RESP_OKAY) model[idx] = merge(model[idx], d, strb);
            if (burst != AXI_BURST_FIXED) idx = idx + 10'd1;
        end
        check("bvalid_after_last", 64'(bvalid), 64'd1);
        get_b();
    endtask

    task automatic push_read(input logic [63:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic id, input logic [1:0] resp);
        logic [9:0] idx;
        idx = addr[12:3];
        for (int b = 0; b <= int'(len); b++) begin
            r_q.push_back('{data: (resp == AXI_RESP_OKAY) ? model[idx] : 64'd0,
                            resp: resp, last: (b == int'(len)), id: id});
            if (burst != AXI_BURST_FIXED) idx = idx + 10'd1;
        end
    endtask

    task automatic do_ar(input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic id);
        bit hs;
        hs = 1'b0;
        araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arid = id; arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (arready === 1'b1) begin
                check("rvalid_before_ar", 64'(rvalid), 64'd0);
                hs = 1'b1; tick(); break;
            end
            tick();
        end
        arvalid = 1'b0;
        check("ar_handshake", 64'(hs), 64'd1);
        check("rvalid_ar_plus1", 64'(rvalid), 64'd1);
    endtask

    // Accept n beats; with toggle, rready alternates 1/0 and stalled beats must hold.
    task automatic collect(input int n, input bit toggle);
        int got;
        rbeat_t e;
        got = 0;
        for (int c = 0; c < 200 && got < n; c++) begin
            rready = toggle ? ((c % 2) == 0) : 1'b1;
            if (rvalid === 1'b1 && r_q.size() > 0) begin
                e = r_q[0];
                check("rdata", rdata, e.data);
                check("rlast", 64'(rlast), 64'(e.last));
                if (rready) begin
                    check("rresp", 64'(rresp), 64'(e.resp));
                    check("rid", 64'(rid), 64'(e.id));
                    void'(r_q.pop_front());
                    got++;
                end
            end
            tick();
        end
        rready = 1'b0;
        check("r_beat_count", 64'(got), 64'(n));
    endtask

    task automatic read_burst(input logic [63:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic id,
                              input logic [1:0] resp, input bit toggle);
        push_read(addr, len, burst, id, resp);
        do_ar(addr, len, burst, id);
        collect(int'(len) + 1, toggle);
        check("r_queue_drained", 64'(r_q.size()), 64'd0);
        check("rvalid_after_last", 64'(rvalid), 64'd0);
        check("arready_after_last", 64'(arready), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        awaddr = 64'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0; awid = 1'b0; awvalid = 1'b0;
        wdata = 64'd0; wstrb = 8'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = 64'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0; arid = 1'b0; arvalid = 1'b0;
        rready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        wvalid = 1'b1;   // W before AW must not be accepted
        tick();

        check("rst_awready", 64'(awready), 64'd1);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rlast", 64'(rlast), 64'd0);
        check("rst_resps", {60'd0, bresp, rresp}, 64'd0);
        check("rst_ids_users", {60'd0, bid, rid, buser, ruser}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        wvalid = 1'b0;

        // Basic 4-beat INCR write and readback
        write_burst(64'h40, 8'd3, AXI_BURST_INCR, 1'b1, 64'h11, 8'hFF, 3, AXI_RESP_OKAY);
        read_burst(64'h40, 8'd3, AXI_BURST_INCR, 1'b1, AXI_RESP_OKAY, 1'b0);
        check("beat0_const", model[8], 64'h11);

        // FIXED read repeats the same word
        read_burst(64'h48, 8'd1, AXI_BURST_FIXED, 1'b0, AXI_RESP_OKAY, 1'b0);

        // Partial strobe keeps the upper word
        write_burst(64'h0, 8'd0, AXI_BURST_INCR, 1'b1, 64'h01234567_89ABCDEF, 8'hFF, 0, AXI_RESP_OKAY);
        write_burst(64'h0, 8'd0, AXI_BURST_INCR, 1'b0, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 0, AXI_RESP_OKAY);
        check("strb_model", model[0], 64'h01234567_BBBBBBBB);
        read_burst(64'h0, 8'd0, AXI_BURST_INCR, 1'b0, AXI_RESP_OKAY, 1'b0);

        // 8-beat burst read back with rready toggling
        write_burst(64'h100, 8'd7, AXI_BURST_INCR, 1'b0, 64'h01010101_01010101, 8'hFF, 7, AXI_RESP_OKAY);
        read_burst(64'h100, 8'd7, AXI_BURST_INCR, 1'b1, AXI_RESP_OKAY, 1'b1);

        // Out-of-range write errors and leaves word 0 untouched
        write_burst(64'h1 << 40, 8'd0, AXI_BURST_INCR, 1'b1, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0,
                    AXI_RESP_SLVERR);
        read_burst(64'h0, 8'd0, AXI_BURST_INCR, 1'b1, AXI_RESP_OKAY, 1'b0);

        // WRAP read: two zero beats with SLVERR
        read_burst(64'h40, 8'd1, AXI_BURST_WRAP, 1'b0, AXI_RESP_SLVERR, 1'b0);

        // Early wlast on beat 2 of a 4-beat write
        write_burst(64'h800, 8'd3, AXI_BURST_INCR, 1'b1, 64'h5A, 8'hFF, 1, AXI_RESP_SLVERR);

        // Reset in the middle of a 16-beat read after 5 beats
        push_read(64'h100, 8'd15, AXI_BURST_INCR, 1'b1, AXI_RESP_OKAY);
        do_ar(64'h100, 8'd15, AXI_BURST_INCR, 1'b1);
        collect(5, 1'b0);
        reset = 1'b1;
        tick();
        check("midrst_rvalid", 64'(rvalid), 64'd0);
        check("midrst_arready", 64'(arready), 64'd1);
        reset = 1'b0;
        r_q.delete();
        tick();
        read_burst(64'h40, 8'd3, AXI_BURST_INCR, 1'b0, AXI_RESP_OKAY, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
